ctrl_fetch_decode: RTL
======================

Name: ctrl_fetch_decode

Overview:
Instruction fetch and decode controller sitting directly upstream of the register file. It holds the PC, fetches 16-bit instruction words from instruction memory over a req/ack handshake, and decodes them into register-file control (source/destination indices, write enable, MOVI strobes, immediate). It also emits a single-cycle register-file clock enable per executed instruction and drives a data-memory handshake for LOAD/STORE.

Parameters:
PC_WIDTH, 8, width of PC and imem_addr_po; PC wraps modulo 2^PC_WIDTH
RESET_PC, 0, PC value loaded on reset

Ports:
clk_pi  in  1  clock, all state on rising edge
reset_n_pi  in  1  asynchronous, active-low reset
imem_req_po  out  1  instruction fetch request
imem_addr_po  out  PC_WIDTH  fetch address (= PC)
imem_ack_pi  in  1  fetch data valid this cycle
imem_data_pi  in  16  instruction word
dmem_req_po  out  1  data memory request
dmem_we_po  out  1  1 = STORE, 0 = LOAD
dmem_ack_pi  in  1  data access complete
source_reg1_po  out  3  IR[8:6]; LOAD/STORE address register
source_reg2_po  out  3  IR[5:3]
destination_reg_po  out  3  IR[11:9]; also STORE data register
wr_destination_reg_po  out  1  register write strobe
movi_lower_po  out  1  MOVIL strobe
movi_higher_po  out  1  MOVIH strobe
immediate_po  out  8  IR[7:0]
alu_func_po  out  4  IR[15:12]
wb_sel_mem_po  out  1  1 = write-back data from dmem (LOAD)
rf_clk_en_po  out  1  register-file clock enable, one pulse per instruction
pc_po  out  PC_WIDTH  current PC
halted_po  out  1  processor halted

Behaviour:
- Opcodes IR[15:12]: 0 NOP; 1-A ALU ops (ADD, ADDC, SUB, SUBB, AND, OR, XOR, NOT, SHL, SHR); B MOVIL; C MOVIH; D LOAD; E STORE; F HALT.
- Reset (async, reset_n_pi=0):
  - PC=RESET_PC, IR=0, state FETCH.
  - All outputs 0, except imem_req_po=1 and imem_addr_po=RESET_PC once reset is released.
- FETCH:
  - imem_req_po=1, imem_addr_po=PC, held until imem_ack_pi is sampled high.
  - On that edge IR<=imem_data_pi and state->DECODE.
  - Request is decoded from state; it drops the cycle after ack.
- DECODE (1 cycle): field outputs register from IR. Next state:
  - MEM for D/E
  - HALT for F
  - EXEC for everything else
- MEM:
  - dmem_req_po=1; dmem_we_po=1 for STORE, 0 for LOAD.
  - Held until dmem_ack_pi is sampled high.
  - Then LOAD->EXEC; STORE->PC+1, FETCH. STORE never pulses rf_clk_en_po.
- EXEC (1 cycle):
  - rf_clk_en_po=1 for opcodes 1-D.
  - wr_destination_reg_po=1 for 1-A and D; wb_sel_mem_po=1 for D only.
  - movi_lower_po=1 for B; movi_higher_po=1 for C.
  - NOP: rf_clk_en_po=0 so flags are not disturbed.
  - Exit: PC<=PC+1, state->FETCH.
- HALT: halted_po=1; all strobes and requests are 0; exited only by reset.
- Strobes (rf_clk_en_po, wr_destination_reg_po, movi_*, wb_sel_mem_po) are 0 outside EXEC. Field outputs hold their last decoded values until the next DECODE.
- Latency with zero-wait ack:
  - ALU/MOVI: 3 cycles per instruction.
  - LOAD: 4 cycles; STORE: 3 cycles.
- Acks arriving while the matching request is 0 are ignored.
- PC at all ones increments to 0.
- Reset asserted mid-FETCH or mid-MEM: the request drops immediately (asynchronously) and the transaction is abandoned; no strobe is emitted.

Optional Feature:
CTRL_SINGLE_STEP_EN
- Defined:
  - Adds input step_pi (1 bit).
  - EXEC and STORE-completion go to state STEP_WAIT instead of FETCH. PC is still incremented on entry.
  - STEP_WAIT leaves for FETCH on the first cycle step_pi=1.
  - All requests and strobes are 0 in STEP_WAIT.
  - After reset, FETCH is entered directly (first instruction needs no step).
- Undefined: port absent; behaviour exactly as above.

Test Plan:
- Reset then zero-wait imem returning 0x1250 (ADD $1,$1,$2) at addr 0 -> rf_clk_en_po=1 and wr_destination_reg_po=1 in cycle 3; dest=1, src1=1, src2=2, alu_func=1; pc_po=1 after.
- imem ack delayed 4 cycles, data 0xB6A5 (MOVIL $3,0xA5) -> imem_req_po held 5 cycles with addr stable; then movi_lower_po=1, immediate_po=0xA5, wr_destination_reg_po=0.
- LOAD 0xD440 with dmem ack after 2 cycles -> dmem_req_po=1 and dmem_we_po=0 for 3 cycles; then EXEC with wb_sel_mem_po=1, dest=2. STORE 0xE440 -> dmem_we_po=1 and no rf_clk_en_po pulse.
- Program NOP, HALT (0x0000, 0xF000) -> no rf_clk_en_po for the NOP; halted_po=1, requests stay 0 for 20 cycles; reset_n_pi low -> halted_po=0 and PC=RESET_PC.
- PC_WIDTH=2, four ADDs -> imem_addr_po sequence 0,1,2,3,0; reset_n_pi pulsed mid-FETCH -> imem_req_po falls in the same cycle with no strobe.
- With CTRL_SINGLE_STEP_EN -> after first ADD, no imem_req_po until step_pi=1; then one fetch at addr 1.

Source files
------------

// File: rtl/ctrl_fetch_decode.sv
// ctrl_fetch_decode: instruction fetch/decode controller in front of the register file.
// Fetches 16-bit words over an imem req/ack handshake, decodes them into
// register-file controls, issues a one-cycle rf clock enable per executed
// instruction and runs a dmem handshake for LOAD/STORE.
// Optional build macro: CTRL_SINGLE_STEP_EN adds step_pi and a STEP_WAIT
// state that gates each fetch after the first one behind a step pulse.
module ctrl_fetch_decode #(
   parameter int PC_WIDTH = 8,
   parameter int RESET_PC = 0
) (
   input  logic                clk_pi,
   input  logic                reset_n_pi,
`ifdef CTRL_SINGLE_STEP_EN
   input  logic                step_pi,
`endif
   output logic                imem_req_po,
   output logic [PC_WIDTH-1:0] imem_addr_po,
   input  logic                imem_ack_pi,
   input  logic [15:0]         imem_data_pi,
   output logic                dmem_req_po,
   output logic                dmem_we_po,
   input  logic                dmem_ack_pi,
   output logic [2:0]          source_reg1_po,
   output logic [2:0]          source_reg2_po,
   output logic [2:0]          destination_reg_po,
   output logic                wr_destination_reg_po,
   output logic                movi_lower_po,
   output logic                movi_higher_po,
   output logic [7:0]          immediate_po,
   output logic [3:0]          alu_func_po,
   output logic                wb_sel_mem_po,
   output logic                rf_clk_en_po,
   output logic [PC_WIDTH-1:0] pc_po,
   output logic                halted_po
);

   localparam logic [PC_WIDTH-1:0] RESET_PC_V = PC_WIDTH'(RESET_PC);

   localparam logic [2:0] ST_FETCH  = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_MEM    = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_HALT   = 3'd4;
`ifdef CTRL_SINGLE_STEP_EN
   localparam logic [2:0] ST_STEP_WAIT = 3'd5;
   // Where a retiring instruction goes once PC has been advanced.
   localparam logic [2:0] ST_RETIRE    = ST_STEP_WAIT;
`else
   localparam logic [2:0] ST_RETIRE    = ST_FETCH;
`endif

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_ALU_L = 4'h1;
   localparam logic [3:0] OP_ALU_H = 4'hA;
   localparam logic [3:0] OP_MOVIL = 4'hB;
   localparam logic [3:0] OP_MOVIH = 4'hC;
   localparam logic [3:0] OP_LOAD  = 4'hD;
   localparam logic [3:0] OP_STORE = 4'hE;
   localparam logic [3:0] OP_HALT  = 4'hF;

   logic [2:0]          state_reg, state_next;
   logic [PC_WIDTH-1:0] pc_reg, pc_next;
   logic [15:0]         ir_reg;
   logic [2:0]          src1_reg, src2_reg, dest_reg;
   logic [7:0]          imm_reg;
   logic [3:0]          func_reg;
   logic                in_exec;

   // Next-state and PC-advance logic of the fetch/decode/execute sequencer.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      case (state_reg)
         ST_FETCH: begin
            if (imem_ack_pi) state_next = ST_DECODE;
         end
         ST_DECODE: begin
            case (ir_reg[15:12])
               OP_LOAD, OP_STORE: state_next = ST_MEM;
               OP_HALT:           state_next = ST_HALT;
               default:           state_next = ST_EXEC;
            endcase
         end
         ST_MEM: begin
            if (dmem_ack_pi) begin
               if (func_reg == OP_STORE) begin
                  // STORE retires straight from MEM without touching the rf.
                  pc_next    = pc_reg + 1'b1;
                  state_next = ST_RETIRE;
               end else begin
                  state_next = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            pc_next    = pc_reg + 1'b1;
            state_next = ST_RETIRE;
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
`ifdef CTRL_SINGLE_STEP_EN
         ST_STEP_WAIT: begin
            if (step_pi) state_next = ST_FETCH;
         end
`endif
         default: state_next = ST_FETCH;
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         state_reg <= ST_FETCH;
         pc_reg    <= RESET_PC_V;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
      end
   end

   // Instruction register captures the fetched word on the acknowledged edge.
   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         ir_reg <= '0;
      end else if (state_reg == ST_FETCH && imem_ack_pi) begin
         ir_reg <= imem_data_pi;
      end
   end

   // Decoded fields are latched in DECODE and hold until the next DECODE.
   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         src1_reg <= '0;
         src2_reg <= '0;
         dest_reg <= '0;
         imm_reg  <= '0;
         func_reg <= '0;
      end else if (state_reg == ST_DECODE) begin
         src1_reg <= ir_reg[8:6];
         src2_reg <= ir_reg[5:3];
         dest_reg <= ir_reg[11:9];
         imm_reg  <= ir_reg[7:0];
         func_reg <= ir_reg[15:12];
      end
   end

   // Requests are gated by reset so they fall the instant reset asserts;
   // the state register is already async-cleared, this also covers FETCH.
   assign imem_req_po  = reset_n_pi && (state_reg == ST_FETCH);
   assign imem_addr_po = reset_n_pi ? pc_reg : '0;
   assign dmem_req_po  = (state_reg == ST_MEM);
   assign dmem_we_po   = (state_reg == ST_MEM) && (func_reg == OP_STORE);

   // Strobes only ever fire in EXEC; NOP leaves the rf clock off so flags hold.
   assign in_exec               = (state_reg == ST_EXEC);
   assign rf_clk_en_po          = in_exec && (func_reg != OP_NOP) && (func_reg <= OP_LOAD);
   assign wr_destination_reg_po = in_exec && (((func_reg >= OP_ALU_L) && (func_reg <= OP_ALU_H))
                                              || (func_reg == OP_LOAD));
   assign wb_sel_mem_po         = in_exec && (func_reg == OP_LOAD);
   assign movi_lower_po         = in_exec && (func_reg == OP_MOVIL);
   assign movi_higher_po        = in_exec && (func_reg == OP_MOVIH);

   assign source_reg1_po     = src1_reg;
   assign source_reg2_po     = src2_reg;
   assign destination_reg_po = dest_reg;
   assign immediate_po       = imm_reg;
   assign alu_func_po        = func_reg;
   assign pc_po              = pc_reg;
   assign halted_po          = (state_reg == ST_HALT);

endmodule
